if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Consumer side of the program-counter interface. Samples pc and issues a req/ack read
//  to instruction memory. Captures the returned word into the IF/ID output register.
//  Drives pc_write (3'b111 = advance, 3'b000 = hold) back to the program counter.
//  Sits between the program counter, the I-memory port and the decode stage.
// PARAMETERS
//  RESET_PC  32'h00003000  reset value of imem_addr/if_pc (PC reset vector)
//  NOP_INSTR 32'h00000000  word placed on if_instr when invalid/faulted
// PORTS
//  clk         in   1   single clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  pc          in   32  current PC; changes only after a pc_write=3'b111 cycle
//  flush       in   1   redirect: discard buffered/in-flight fetch
//  id_stall    in   1   decode not accepting; if_* must hold
//  imem_req    out  1   read request, held until imem_ack
//  imem_addr   out  32  read address, stable while imem_req && !imem_ack
//  imem_ack    in   1   read done; imem_rdata valid this cycle
//  imem_rdata  in   32  instruction word
//  if_valid    out  1   if_instr/if_pc valid for decode
//  if_instr    out  32  fetched instruction
//  if_pc       out  32  address of if_instr
//  if_fault    out  1   misaligned fetch reported with if_valid
//  pc_write    out  3   3'b111 advance PC, 3'b000 hold; registered
// BEHAVIOUR
//  Reset (sync): state=LOAD, imem_req=0, imem_addr=RESET_PC, if_valid=0,
//   if_instr=NOP_INSTR, if_pc=RESET_PC, if_fault=0, pc_write=3'b000.
//  Consume: if_valid && !id_stall at a posedge. Slot free = !if_valid or consume.
//  FSM:
//   LOAD: req_addr<=pc. If pc[1:0]!=0 -> FAULT, else -> REQ. imem_req=0.
//   REQ: imem_req=1, imem_addr=req_addr, held unchanged until ack.
//    On ack with slot free: if_instr<=rdata, if_pc<=req_addr, if_valid<=1 -> ADV.
//    On ack with slot busy: skid<=rdata -> HOLD.
//   HOLD: imem_req=0. On consume: if_*<=skid/req_addr, if_valid<=1 -> ADV.
//   ADV: pc_write=3'b111 for exactly this cycle; PC updates within it -> LOAD.
//   FAULT: if slot free: if_valid<=1, if_fault<=1, if_instr<=NOP_INSTR,
//    if_pc<=req_addr. Then stay; no request; pc_write=000 until flush/reset.
//   DRAIN: imem_req=1, same address; on ack discard rdata -> LOAD.
//  pc_write=3'b000 in every state except ADV.
//  Zero-wait memory (ack same cycle as req): one instruction per 3 cycles (REQ,ADV,LOAD).
//  if_valid clears on consume unless a new word loads the same edge.
//  flush (priority over all but reset), at posedge:
//   if_valid<=0, if_fault<=0, skid discarded, pc_write=000 (hazard unit loads PC).
//   In REQ without ack -> DRAIN (request must complete); in REQ with ack -> LOAD, data dropped.
//   Any other state -> LOAD.
//  Reset mid-REQ: imem_req drops next cycle; the memory must tolerate an abandoned request.
//  id_stall with !if_valid has no effect.
// TESTING
//  1 reset, pc=0x3000, ack same cycle -> imem_addr=0x3000; if_valid next cycle; pc_write=111 one cycle.
//  2 ack delayed 3 cycles -> imem_req/imem_addr stable 4 cycles; pc_write=000 throughout wait.
//  3 if_valid, id_stall=1, ack rdata=0xAABBCCDD -> HOLD; if_instr unchanged; on release 0xAABBCCDD, then pc_write=111.
//  4 flush during REQ, ack 2 cycles later -> DRAIN, data dropped; next req at new pc 0x3100; if_valid=0.
//  5 pc=0x3002 -> no imem_req; if_valid=1, if_fault=1, if_instr=0; flush+pc=0x3004 recovers.
//  6 reset asserted in REQ -> next cycle all outputs at reset values, state LOAD.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: samples the PC, runs a req/ack read on the I-memory port,
// and presents the returned word to decode with a one-entry skid for decode stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault,
  output logic [2:0]  pc_write
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    ADV   = 3'd3,
    FAULT = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] req_addr;
  logic [31:0] skid;
  logic        fault_sent;

  logic consume;
  logic slot_free;
  logic sample_pc;
  logic load_word;
  logic load_skid;
  logic load_fault;
  logic capture_skid;

  assign consume   = if_valid && !id_stall;
  assign slot_free = !if_valid || consume;

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = req_addr;

  always_comb begin
    state_next   = state;
    sample_pc    = 1'b0;
    load_word    = 1'b0;
    load_skid    = 1'b0;
    load_fault   = 1'b0;
    capture_skid = 1'b0;
    case (state)
      LOAD: begin
        sample_pc  = 1'b1;
        state_next = (pc[1:0] != 2'b00) ? FAULT : REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (slot_free) begin
            load_word  = 1'b1;
            state_next = ADV;
          end else begin
            capture_skid = 1'b1;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          load_skid  = 1'b1;
          state_next = ADV;
        end
      end
      ADV:   state_next = LOAD;
      FAULT: load_fault = slot_free && !fault_sent;
      DRAIN: begin
        if (imem_ack) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase

    // A redirect kills everything except an outstanding memory transaction,
    // which must still see its ack before a new address can be issued.
    if (flush) begin
      sample_pc    = 1'b0;
      load_word    = 1'b0;
      load_skid    = 1'b0;
      load_fault   = 1'b0;
      capture_skid = 1'b0;
      state_next   = ((state == REQ || state == DRAIN) && !imem_ack) ? DRAIN : LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      req_addr   <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= RESET_PC;
      if_fault   <= 1'b0;
      pc_write   <= 3'b000;
      fault_sent <= 1'b0;
    end else begin
      state    <= state_next;
      pc_write <= (state_next == ADV) ? 3'b111 : 3'b000;
      if (sample_pc) req_addr <= pc;

      if (flush) begin
        if_valid   <= 1'b0;
        if_fault   <= 1'b0;
        fault_sent <= 1'b0;
      end else if (load_word || load_skid || load_fault) begin
        if_valid <= 1'b1;
        if_fault <= load_fault;
        if_pc    <= req_addr;
        if_instr <= load_fault ? NOP_INSTR : (load_skid ? skid : imem_rdata);
        if (load_fault) fault_sent <= 1'b1;
      end else if (consume) begin
        if_valid <= 1'b0;
        if_fault <= 1'b0;
      end
    end
  end

  // Skid word is plain data; its validity is carried by the HOLD state.
  always_ff @(posedge clk) begin
    if (capture_skid) skid <= imem_rdata;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push expected memory
// addresses and decode words; a negedge monitor pops and compares them.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
  logic [2:0]  pc_write;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } out_t;

  logic [31:0] exp_addr[$];
  out_t        exp_out[$];

  int          checks;
  int          failures;
  int          ack_delay;
  logic        use_fixed;
  logic [31:0] fixed_word;

  if_fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .flush     (flush),
    .id_stall  (id_stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_fault  (if_fault),
    .pc_write  (pc_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_req"}, imem_req, 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h3000);
    chk({tag, "_if_valid"}, if_valid, 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h3000);
    chk({tag, "_if_fault"}, if_fault, 32'd0);
    chk({tag, "_pc_write"}, pc_write, 32'd0);
  endtask

  task automatic push_out(input logic [31:0] i, input logic [31:0] p, input logic f);
    out_t e;
    e.instr = i;
    e.pc    = p;
    e.fault = f;
    exp_out.push_back(e);
  endtask

  // Program counter model: advances by 4 after a pc_write=111 cycle.
  task automatic tick();
    if (pc_write == 3'b111) pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks after ack_delay wait cycles of a held request.
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (wcnt >= ack_delay) begin
          imem_ack = 1'b1;
          wcnt     = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
      imem_rdata = use_fixed ? fixed_word : (imem_addr ^ 32'h1357_0000);
    end
  end

  // Monitor: every completed memory transaction and every decode handoff is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_req && imem_ack) begin
          if (exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_addr unexpected ack at addr=%h", imem_addr);
          end else begin
            chk("sb_addr", imem_addr, exp_addr.pop_front());
          end
        end
        if (if_valid && !id_stall) begin
          if (exp_out.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_out unexpected word instr=%h pc=%h", if_instr, if_pc);
          end else begin
            out_t e;
            e = exp_out.pop_front();
            chk("sb_instr", if_instr, e.instr);
            chk("sb_pc", if_pc, e.pc);
            chk("sb_fault", if_fault, e.fault);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    pc         = 32'h3000;
    flush      = 1'b0;
    id_stall   = 1'b0;
    ack_delay  = 0;
    use_fixed  = 1'b0;
    fixed_word = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");

    // Zero-wait fetch
    exp_addr.push_back(32'h3000);
    push_out(32'h1357_3000, 32'h3000, 1'b0);
    reset = 1'b0;
    tick();
    chk("t1_req", imem_req, 32'd1);
    chk("t1_addr", imem_addr, 32'h3000);
    chk("t1_pw_req", pc_write, 32'd0);
    tick();
    chk("t1_valid", if_valid, 32'd1);
    chk("t1_pw_adv", pc_write, 32'h7);
    ack_delay = 3;
    tick();
    chk("t1_pw_once", pc_write, 32'd0);

    // Three wait cycles on the memory
    exp_addr.push_back(32'h3004);
    push_out(32'h1357_3004, 32'h3004, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", imem_req, 32'd1);
      chk("t2_addr", imem_addr, 32'h3004);
      chk("t2_pw", pc_write, 32'd0);
      tick();
    end
    chk("t2_valid", if_valid, 32'd1);
    chk("t2_pw_adv", pc_write, 32'h7);

    // Decode stall forces the next word into the skid
    id_stall   = 1'b1;
    use_fixed  = 1'b1;
    fixed_word = 32'hAABB_CCDD;
    ack_delay  = 0;
    tick();
    exp_addr.push_back(32'h3008);
    tick();
    chk("t3_req", imem_req, 32'd1);
    tick();
    chk("t3_hold_instr", if_instr, 32'h1357_3004);
    chk("t3_hold_req", imem_req, 32'd0);
    chk("t3_hold_pw", pc_write, 32'd0);
    tick();
    chk("t3_hold_valid", if_valid, 32'd1);
    chk("t3_hold_instr2", if_instr, 32'h1357_3004);
    push_out(32'hAABB_CCDD, 32'h3008, 1'b0);
    id_stall = 1'b0;
    tick();
    chk("t3_skid_instr", if_instr, 32'hAABB_CCDD);
    chk("t3_skid_pc", if_pc, 32'h3008);
    chk("t3_pw_adv", pc_write, 32'h7);
    use_fixed = 1'b0;
    ack_delay = 3;

    // Flush while a request is outstanding
    tick();
    exp_addr.push_back(32'h300C);
    tick();
    chk("t4_req", imem_req, 32'd1);
    chk("t4_addr", imem_addr, 32'h300C);
    flush = 1'b1;
    pc    = 32'h3100;
    tick();
    flush = 1'b0;
    chk("t4_drain_req", imem_req, 32'd1);
    chk("t4_drain_addr", imem_addr, 32'h300C);
    chk("t4_drain_valid", if_valid, 32'd0);
    tick();
    tick();
    tick();
    chk("t4_load_req", imem_req, 32'd0);
    chk("t4_load_valid", if_valid, 32'd0);
    chk("t4_load_pw", pc_write, 32'd0);
    ack_delay = 0;
    exp_addr.push_back(32'h3100);
    push_out(32'h1357_3100, 32'h3100, 1'b0);
    tick();
    chk("t4_new_addr", imem_addr, 32'h3100);
    tick();
    chk("t4_new_instr", if_instr, 32'h1357_3100);
    chk("t4_new_pw", pc_write, 32'h7);

    // Misaligned PC reports a fault once, then recovers on flush
    tick();
    pc = 32'h3002;
    push_out(32'h0, 32'h3002, 1'b1);
    tick();
    chk("t5_noreq", imem_req, 32'd0);
    tick();
    chk("t5_valid", if_valid, 32'd1);
    chk("t5_fault", if_fault, 32'd1);
    chk("t5_instr", if_instr, 32'h0);
    chk("t5_pc", if_pc, 32'h3002);
    chk("t5_pw", pc_write, 32'd0);
    tick();
    chk("t5_cleared", if_valid, 32'd0);
    tick();
    chk("t5_once", if_valid, 32'd0);
    chk("t5_idle_req", imem_req, 32'd0);
    flush = 1'b1;
    pc    = 32'h3004;
    tick();
    flush = 1'b0;
    chk("t5_flush_fault", if_fault, 32'd0);
    exp_addr.push_back(32'h3004);
    push_out(32'h1357_3004, 32'h3004, 1'b0);
    tick();
    chk("t5_rec_req", imem_req, 32'd1);
    chk("t5_rec_addr", imem_addr, 32'h3004);
    tick();
    chk("t5_rec_pw", pc_write, 32'h7);
    ack_delay = 5;

    // Reset while a request is held
    tick();
    tick();
    chk("t6_req", imem_req, 32'd1);
    chk("t6_addr", imem_addr, 32'h3008);
    reset = 1'b1;
    tick();
    chk_reset("t6");
    reset = 1'b0;
    tick();
    tick();
    chk("end_addr_q", exp_addr.size(), 32'd0);
    chk("end_out_q", exp_out.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
